pipeline_stage_chain: RTL and testbench

- Parametrised successor to the single fetch/decode latch: a chain of DEPTH pipeline registers of WIDTH bits, each with a valid bit.
- Each stage has its own stall and flush (NOP insert) control. Stalls propagate backward automatically.
- Optional bubble collapsing lets an empty stage fill while a downstream stage is held.
- Used between any two datapath stages, or as a multi-stage delay line for the execute/memory/writeback boundaries.

---
 rtl/pipeline_stage_chain.sv | 176 +++++++++++++++++
 tb/tb_pipeline_stage_chain.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_chain.sv
// -----------------------------------------------------------------------------
// pipeline_stage_chain
//
// A chain of DEPTH pipeline registers, each WIDTH bits wide with a valid bit.
// Each stage has its own stall and flush control. A stall on one stage holds
// every stage upstream of it. With COLLAPSE=1, a held stage that is empty
// (valid=0) still accepts new data, so a bubble can close up while the stages
// downstream of it are held.
//
// Parameters:
//   WIDTH     payload bits per stage
//   DEPTH     number of register stages (>= 1)
//   NOP_VALUE payload loaded on reset, on flush, and for any invalid entry
//   COLLAPSE  1 = a held stage with valid=0 accepts new data
//
// Ports:
//   CLK          clock; all state updates on the rising edge
//   RST          synchronous, active-high reset; overrides stall and flush
//   in_data      payload into stage 0
//   in_valid     in_data is a real entry
//   in_ready     stage 0 loads on this edge (= ~hold[0])
//   stall[i]     stage i keeps its contents
//   flush[i]     stage i loads (NOP_VALUE, 0) on this edge
//   stage_data   all stage payloads; stage i at [i*WIDTH +: WIDTH]
//   stage_valid  valid bit of each stage
//   out_data     payload of stage DEPTH-1
//   out_valid    valid bit of stage DEPTH-1
//   occupancy    number of valid stages
//
// Handshake: the upstream side presents in_data/in_valid. The entry is
// captured on a rising edge only when in_ready=1 on that edge. When in_ready=0,
// upstream keeps presenting the same entry. The downstream side has no ready
// signal; it holds the last stage by asserting stall[DEPTH-1].
//
// Optional feature (macro PIPE_PERF_EN): when the macro is defined, three
// 32-bit wrapping counters are added. Reset clears all three.
//   perf_stall_cycles  counts cycles with in_valid & ~in_ready
//   perf_squashed      counts, per edge, the valid stages that are flushed
//   perf_bubbles_out   counts cycles with out_valid=0 & ~stall[DEPTH-1]
// -----------------------------------------------------------------------------
module pipeline_stage_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               COLLAPSE  = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DEPTH-1:0]           stall,
    input  logic [DEPTH-1:0]           flush,
    output logic [DEPTH*WIDTH-1:0]     stage_data,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]                perf_stall_cycles,
    output logic [31:0]                perf_squashed,
    output logic [31:0]                perf_bubbles_out
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [DEPTH-1:0] w_hold;
    logic [WIDTH-1:0] w_src_data [DEPTH];
    logic [DEPTH-1:0] w_src_valid;
    logic [OCC_W-1:0] w_occ;

    // Hold ripples from the output end back toward the input. w_chain is
    // hold[i+1] as the loop walks down, starting from hold[DEPTH] = 0. With
    // COLLAPSE=1, an empty stage breaks the chain, so it and the stages
    // upstream of it can keep moving.
    always_comb begin
        logic w_chain;
        w_chain = 1'b0;
        w_hold  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (COLLAPSE != 0) begin
                w_chain = stall[i] | (w_chain & r_valid[i]);
            end else begin
                w_chain = stall[i] | w_chain;
            end
            w_hold[i] = w_chain;
        end
    end

    // Stage 0 takes NOP_VALUE for an invalid input. Flush also loads
    // NOP_VALUE, so every invalid entry in the chain carries NOP_VALUE.
    always_comb begin
        w_src_data[0]  = in_valid ? in_data : NOP_VALUE;
        w_src_valid[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_data[i]  = r_data[i-1];
            w_src_valid[i] = r_valid[i-1];
        end
    end

    // Priority: reset > flush > hold > advance. Flushing stage i does not
    // change what stage i+1 samples on the same edge; stage i+1 takes the
    // pre-flush contents of stage i.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (RST || flush[i]) begin
                r_data[i]  <= NOP_VALUE;
                r_valid[i] <= 1'b0;
            end else if (!w_hold[i]) begin
                r_data[i]  <= w_src_data[i];
                r_valid[i] <= w_src_valid[i];
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    always_comb begin
        stage_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_data[i*WIDTH +: WIDTH] = r_data[i];
        end
    end

    assign in_ready    = ~w_hold[0];
    assign stage_valid = r_valid;
    assign out_data    = r_data[DEPTH-1];
    assign out_valid   = r_valid[DEPTH-1];
    assign occupancy   = w_occ;

`ifdef PIPE_PERF_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_squashed;
    logic [31:0] r_perf_bubbles_out;
    logic [31:0] w_squash_cnt;

    // Several stages can be squashed on one edge, so add the count of them.
    always_comb begin
        w_squash_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_squash_cnt = w_squash_cnt + 32'(flush[i] & r_valid[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_perf_stall_cycles <= '0;
            r_perf_squashed     <= '0;
            r_perf_bubbles_out  <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
            r_perf_squashed <= r_perf_squashed + w_squash_cnt;
            if (!r_valid[DEPTH-1] && !stall[DEPTH-1]) begin
                r_perf_bubbles_out <= r_perf_bubbles_out + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_squashed     = r_perf_squashed;
    assign perf_bubbles_out  = r_perf_bubbles_out;
`endif

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Bench for pipeline_stage_chain with WIDTH=32, DEPTH=3, NOP_VALUE=0.
// dut_c0 is built with COLLAPSE=0 and dut_c1 with COLLAPSE=1. Both receive the
// same inputs, so the two can be compared where their behaviour differs.
module tb_pipeline_stage_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic [2:0]  stall;
  logic [2:0]  flush;

  logic        c0_ready, c1_ready;
  logic [95:0] c0_sd, c1_sd;
  logic [2:0]  c0_sv, c1_sv;
  logic [31:0] c0_od, c1_od;
  logic        c0_ov, c1_ov;
  logic [1:0]  c0_occ, c1_occ;
`ifdef PIPE_PERF_EN
  logic [31:0] c0_pst, c0_psq, c0_pbo;
  logic [31:0] c1_pst, c1_psq, c1_pbo;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stage_chain #(.WIDTH(32), .DEPTH(3), .NOP_VALUE(32'h0), .COLLAPSE(0)) dut_c0 (
    .CLK(clk), .RST(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(c0_ready),
    .stall(stall), .flush(flush), .stage_data(c0_sd), .stage_valid(c0_sv),
    .out_data(c0_od), .out_valid(c0_ov), .occupancy(c0_occ)
`ifdef PIPE_PERF_EN
    , .perf_stall_cycles(c0_pst), .perf_squashed(c0_psq), .perf_bubbles_out(c0_pbo)
`endif
  );

  pipeline_stage_chain #(.WIDTH(32), .DEPTH(3), .NOP_VALUE(32'h0), .COLLAPSE(1)) dut_c1 (
    .CLK(clk), .RST(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(c1_ready),
    .stall(stall), .flush(flush), .stage_data(c1_sd), .stage_valid(c1_sv),
    .out_data(c1_od), .out_valid(c1_ov), .occupancy(c1_occ)
`ifdef PIPE_PERF_EN
    , .perf_stall_cycles(c1_pst), .perf_squashed(c1_psq), .perf_bubbles_out(c1_pbo)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; stall = 3'b000; flush = 3'b000;
    step();
    rst = 1'b0;
  endtask

  // Leaves s2=a, s1=b, s0=c (all valid) with no stalls applied.
  task automatic fill3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    stall = 3'b000; flush = 3'b000;
    in_valid = 1'b1; in_data = a; step();
    in_data = b; step();
    in_data = c; step();
    in_valid = 1'b0; in_data = 32'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (c0_sv !== 3'b000) begin errors++; $display("FAIL reset_valid got=%b exp=000", c0_sv); end
    checks++; if (c0_sd !== 96'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", c0_sd); end
    checks++; if (c0_occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", c0_occ); end
    checks++; if (c0_ov !== 1'b0 || c0_od !== 32'h0) begin errors++; $display("FAIL reset_out got=%b/%h exp=0/0", c0_ov, c0_od); end
    checks++; if (c0_ready !== 1'b1 || c1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", c0_ready, c1_ready); end
    checks++; if (c1_sv !== 3'b000) begin errors++; $display("FAIL reset_valid_c1 got=%b exp=000", c1_sv); end
  endtask

  task automatic test_stream();
    logic [31:0] d_tab [7];
    logic        v_tab [7];
    logic [31:0] od_tab [7];
    logic        ov_tab [7];
    logic [1:0]  occ_tab [7];
    d_tab   = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    v_tab   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    od_tab  = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0};
    ov_tab  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    occ_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      in_valid = v_tab[k]; in_data = d_tab[k];
      #1;
      checks++; if (c0_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b exp=1", k, c0_ready); end
      step();
      checks++; if (c0_od !== od_tab[k] || c0_ov !== ov_tab[k]) begin
        errors++; $display("FAIL stream_out[%0d] got=%b/%h exp=%b/%h", k, c0_ov, c0_od, ov_tab[k], od_tab[k]);
      end
      checks++; if (c0_occ !== occ_tab[k]) begin errors++; $display("FAIL stream_occ[%0d] got=%0d exp=%0d", k, c0_occ, occ_tab[k]); end
      checks++; if (c1_od !== od_tab[k]) begin errors++; $display("FAIL stream_out_c1[%0d] got=%h exp=%h", k, c1_od, od_tab[k]); end
    end
  endtask

  task automatic test_backward_stall();
    do_reset();
    fill3(32'h11, 32'h22, 32'h33);
    checks++; if (c0_sd !== {32'h11, 32'h22, 32'h33}) begin errors++; $display("FAIL bstall_fill got=%h", c0_sd); end
    stall = 3'b100; in_valid = 1'b1; in_data = 32'h44;
    #1;
    checks++; if (c0_ready !== 1'b0 || c1_ready !== 1'b0) begin errors++; $display("FAIL bstall_ready got=%b%b exp=00", c0_ready, c1_ready); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (c0_sd !== {32'h11, 32'h22, 32'h33} || c0_sv !== 3'b111) begin
        errors++; $display("FAIL bstall_hold[%0d] got=%h/%b exp=%h/111", k, c0_sd, c0_sv, {32'h11, 32'h22, 32'h33});
      end
      checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL bstall_ready_held[%0d] got=%b exp=0", k, c0_ready); end
    end
    stall = 3'b000;
    #1;
    checks++; if (c0_ready !== 1'b1) begin errors++; $display("FAIL bstall_release_ready got=%b exp=1", c0_ready); end
    step();
    in_valid = 1'b0; in_data = 32'h0;
    checks++; if (c0_sd !== {32'h22, 32'h33, 32'h44}) begin errors++; $display("FAIL bstall_release got=%h exp=%h", c0_sd, {32'h22, 32'h33, 32'h44}); end
    step();
    checks++; if (c0_od !== 32'h33 || c0_ov !== 1'b1) begin errors++; $display("FAIL bstall_drain1 got=%b/%h exp=1/33", c0_ov, c0_od); end
    step();
    checks++; if (c0_od !== 32'h44 || c0_ov !== 1'b1) begin errors++; $display("FAIL bstall_drain2 got=%b/%h exp=1/44", c0_ov, c0_od); end
    step();
    checks++; if (c0_ov !== 1'b0 || c0_occ !== 2'd0) begin errors++; $display("FAIL bstall_empty got=%b/%0d exp=0/0", c0_ov, c0_occ); end
  endtask

  task automatic test_collapse();
    do_reset();
    in_valid = 1'b1; in_data = 32'h44; step();
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF; step();
    in_valid = 1'b1; in_data = 32'h55; step();
    checks++; if (c1_sd !== {32'h44, 32'h0, 32'h55} || c1_sv !== 3'b101) begin
      errors++; $display("FAIL collapse_setup got=%h/%b exp=%h/101", c1_sd, c1_sv, {32'h44, 32'h0, 32'h55});
    end
    stall = 3'b100; in_data = 32'h66;
    #1;
    checks++; if (c1_ready !== 1'b1) begin errors++; $display("FAIL collapse_ready_c1 got=%b exp=1", c1_ready); end
    checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL collapse_ready_c0 got=%b exp=0", c0_ready); end
    step();
    checks++; if (c1_sd !== {32'h44, 32'h55, 32'h66} || c1_sv !== 3'b111) begin
      errors++; $display("FAIL collapse_squash got=%h/%b exp=%h/111", c1_sd, c1_sv, {32'h44, 32'h55, 32'h66});
    end
    checks++; if (c1_occ !== 2'd3) begin errors++; $display("FAIL collapse_occ got=%0d exp=3", c1_occ); end
    checks++; if (c0_sd !== {32'h44, 32'h0, 32'h55} || c0_sv !== 3'b101) begin
      errors++; $display("FAIL collapse_nocollapse got=%h/%b exp=%h/101", c0_sd, c0_sv, {32'h44, 32'h0, 32'h55});
    end
    in_data = 32'h77;
    #1;
    checks++; if (c1_ready !== 1'b0) begin errors++; $display("FAIL collapse_full_ready got=%b exp=0", c1_ready); end
    step();
    checks++; if (c1_sd !== {32'h44, 32'h55, 32'h66}) begin errors++; $display("FAIL collapse_full_hold got=%h", c1_sd); end
  endtask

  task automatic test_flush_hold();
    do_reset();
    fill3(32'h11, 32'h22, 32'h33);
    stall = 3'b100; flush = 3'b010; in_valid = 1'b0;
    step();
    flush = 3'b000;
    checks++; if (c0_sd !== {32'h11, 32'h0, 32'h33} || c0_sv !== 3'b101) begin
      errors++; $display("FAIL flush_hold got=%h/%b exp=%h/101", c0_sd, c0_sv, {32'h11, 32'h0, 32'h33});
    end
    checks++; if (c0_occ !== 2'd2) begin errors++; $display("FAIL flush_hold_occ got=%0d exp=2", c0_occ); end
    checks++; if (c1_sd !== {32'h11, 32'h0, 32'h33}) begin errors++; $display("FAIL flush_hold_c1 got=%h", c1_sd); end
  endtask

  task automatic test_flush_advance();
    do_reset();
    in_valid = 1'b1; in_data = 32'h77; step();
    flush = 3'b001; in_data = 32'h88;
    step();
    flush = 3'b000; in_valid = 1'b0;
    checks++; if (c0_sd !== {32'h0, 32'h77, 32'h0} || c0_sv !== 3'b010) begin
      errors++; $display("FAIL flush_advance got=%h/%b exp=%h/010", c0_sd, c0_sv, {32'h0, 32'h77, 32'h0});
    end
    checks++; if (c0_occ !== 2'd1) begin errors++; $display("FAIL flush_advance_occ got=%0d exp=1", c0_occ); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fill3(32'h11, 32'h22, 32'h33);
    stall = 3'b100; in_valid = 1'b1; in_data = 32'h99; flush = 3'b010;
    rst = 1'b1;
    step();
    rst = 1'b0; stall = 3'b000; flush = 3'b000; in_valid = 1'b0;
    checks++; if (c0_sv !== 3'b000 || c0_sd !== 96'h0) begin errors++; $display("FAIL midreset_c0 got=%b/%h exp=000/0", c0_sv, c0_sd); end
    checks++; if (c1_sv !== 3'b000 || c1_occ !== 2'd0) begin errors++; $display("FAIL midreset_c1 got=%b/%0d exp=000/0", c1_sv, c1_occ); end
`ifdef PIPE_PERF_EN
    checks++; if (c0_pst !== 32'd0 || c0_psq !== 32'd0 || c0_pbo !== 32'd0) begin
      errors++; $display("FAIL midreset_perf got=%0d/%0d/%0d exp=0/0/0", c0_pst, c0_psq, c0_pbo);
    end
`endif
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_perf();
    do_reset();
    fill3(32'h11, 32'h22, 32'h33);
    checks++; if (c0_pbo !== 32'd3) begin errors++; $display("FAIL perf_bubbles got=%0d exp=3", c0_pbo); end
    stall = 3'b100; in_valid = 1'b1; in_data = 32'hAA;
    step(); step();
    checks++; if (c0_pst !== 32'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", c0_pst); end
    flush = 3'b111;
    step();
    flush = 3'b000;
    checks++; if (c0_psq !== 32'd3) begin errors++; $display("FAIL perf_squash got=%0d exp=3", c0_psq); end
    checks++; if (c0_pst !== 32'd3 || c0_pbo !== 32'd3) begin errors++; $display("FAIL perf_after_flush got=%0d/%0d exp=3/3", c0_pst, c0_pbo); end
    force dut_c0.r_perf_stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut_c0.r_perf_stall_cycles;
    step();
    checks++; if (c0_pst !== 32'd0) begin errors++; $display("FAIL perf_wrap got=%h exp=0", c0_pst); end
    stall = 3'b000; in_valid = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; stall = 3'b000; flush = 3'b000;
    #2;
    test_reset();
    test_stream();
    test_backward_stall();
    test_collapse();
    test_flush_hold();
    test_flush_advance();
    test_mid_reset();
`ifdef PIPE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
